// File: rtl/legv8_multicycle_ctrl_pkg.sv
// rtl/legv8_multicycle_ctrl_pkg.sv - LEGv8 multi-cycle controller types, opcodes and opcode decode
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MUL,
    CLS_DIV,
    CLS_LOAD,
    CLS_STORE,
    CLS_CBZ,
    CLS_B,
    CLS_ILLEGAL
  } cls_t;

  localparam int OPC_LEN = 10;

  localparam logic [OPC_LEN-1:0] OPC_ADD  = 10'b1000101000;
  localparam logic [OPC_LEN-1:0] OPC_SUB  = 10'b1100101100;
  localparam logic [OPC_LEN-1:0] OPC_MUL  = 10'b1111100000;
  localparam logic [OPC_LEN-1:0] OPC_DIV  = 10'b0000011111;
  localparam logic [OPC_LEN-1:0] OPC_LDUR = 10'b1111100010;
  localparam logic [OPC_LEN-1:0] OPC_STUR = 10'b1111100001;
  localparam logic [OPC_LEN-1:0] OPC_CBZ  = 10'b1011010000;
  localparam logic [OPC_LEN-1:0] OPC_B    = 10'b0001010000;

  localparam logic [2:0] ALU_NOP   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_DIV   = 3'b011;
  localparam logic [2:0] ALU_MUL   = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  typedef struct packed {
    cls_t       cls;
    logic [2:0] alu_op;
    logic       mux3;
  } dec_t;

  function automatic dec_t decode_opcode(input logic [OPC_LEN-1:0] opc);
    dec_t d;
    d = '{cls: CLS_ILLEGAL, alu_op: ALU_NOP, mux3: 1'b0};
    case (opc)
      OPC_ADD:  d = '{cls: CLS_ALU,   alu_op: ALU_ADD,   mux3: 1'b1};
      OPC_SUB:  d = '{cls: CLS_ALU,   alu_op: ALU_SUB,   mux3: 1'b1};
      OPC_MUL:  d = '{cls: CLS_MUL,   alu_op: ALU_MUL,   mux3: 1'b1};
      OPC_DIV:  d = '{cls: CLS_DIV,   alu_op: ALU_DIV,   mux3: 1'b1};
      OPC_LDUR: d = '{cls: CLS_LOAD,  alu_op: ALU_ADD,   mux3: 1'b0};
      OPC_STUR: d = '{cls: CLS_STORE, alu_op: ALU_ADD,   mux3: 1'b0};
      OPC_CBZ:  d = '{cls: CLS_CBZ,   alu_op: ALU_PASSB, mux3: 1'b1};
      OPC_B:    d = '{cls: CLS_B,     alu_op: ALU_NOP,   mux3: 1'b0};
      default:  d = '{cls: CLS_ILLEGAL, alu_op: ALU_NOP, mux3: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/legv8_multicycle_ctrl_if.sv
// rtl/legv8_multicycle_ctrl_if.sv - controller bundle toward instruction memory, data memory and datapath
interface legv8_ctrl_if #(
  parameter int OPC_W    = 10,
  parameter int ALU_OP_W = 3
);
  logic [OPC_W-1:0]    opcode;
  logic                instr_valid;
  logic                instr_ready;
  logic                zero_flag;
  logic                mem_ack;
  logic                ir_write;
  logic                pc_write;
  logic                mem_read_dm;
  logic                mem_write_dm;
  logic                branch;
  logic                reg_write_rf;
  logic                mux2;
  logic                mux3;
  logic [ALU_OP_W-1:0] alu_op;
  logic                busy;
  logic                illegal;

  modport master (
    input  opcode, instr_valid, zero_flag, mem_ack,
    output instr_ready, ir_write, pc_write, mem_read_dm, mem_write_dm, branch,
           reg_write_rf, mux2, mux3, alu_op, busy, illegal
  );

  modport slave (
    output opcode, instr_valid, zero_flag, mem_ack,
    input  instr_ready, ir_write, pc_write, mem_read_dm, mem_write_dm, branch,
           reg_write_rf, mux2, mux3, alu_op, busy, illegal
  );
endinterface

// File: rtl/legv8_multicycle_ctrl_exec_counter.sv
// rtl/legv8_multicycle_ctrl_exec_counter.sv - loadable down-counter timing MUL/DIV stalls in EXEC
module legv8_exec_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// rtl/legv8_multicycle_ctrl.sv - LEGv8 FETCH/DECODE/EXEC/MEM/WB sequencer with MUL/DIV stall
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int OPC_W    = 10,
  parameter int ALU_OP_W = 3,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 8
) (
  input logic          clk,
  input logic          rst,
  legv8_ctrl_if.master bus
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_t           state, state_nx;
  logic [OPC_W-1:0] opc_q;
  dec_t             dec;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_load_val;

  assign dec = decode_opcode(opc_q[OPC_W-1 -: OPC_LEN]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      opc_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && bus.instr_valid) begin
        opc_q <= bus.opcode;
      end
    end
  end

  // Loaded in DECODE with latency-1 so EXEC lasts exactly LAT cycles.
  always_comb begin
    cnt_load_val = '0;
    if (dec.cls == CLS_MUL) cnt_load_val = CNT_W'(MUL_LAT - 1);
    if (dec.cls == CLS_DIV) cnt_load_val = CNT_W'(DIV_LAT - 1);
  end

  legv8_exec_counter #(.W(CNT_W)) u_exec_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == S_EXEC && state_nx != S_EXEC),
    .load     (state == S_DECODE),
    .load_val (cnt_load_val),
    .dec      (state == S_EXEC),
    .done     (cnt_done)
  );

  always_comb begin
    state_nx         = state;
    bus.instr_ready  = 1'b0;
    bus.ir_write     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.mem_read_dm  = 1'b0;
    bus.mem_write_dm = 1'b0;
    bus.branch       = 1'b0;
    bus.reg_write_rf = 1'b0;
    bus.mux2         = 1'b0;
    bus.mux3         = 1'b0;
    bus.alu_op       = '0;
    bus.busy         = (state != S_FETCH);
    bus.illegal      = 1'b0;

    unique case (state)
      S_FETCH: begin
        bus.instr_ready = 1'b1;
        bus.ir_write    = bus.instr_valid;
        if (bus.instr_valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (dec.cls == CLS_ILLEGAL) begin
          bus.illegal  = 1'b1;
          bus.pc_write = 1'b1;
          state_nx     = S_FETCH;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        bus.alu_op = ALU_OP_W'(dec.alu_op);
        bus.mux3   = dec.mux3;
        if (cnt_done) begin
          case (dec.cls)
            CLS_LOAD, CLS_STORE: state_nx = S_MEM;
            CLS_CBZ: begin
              bus.pc_write = 1'b1;
              bus.branch   = bus.zero_flag;
              state_nx     = S_FETCH;
            end
            CLS_B: begin
              bus.pc_write = 1'b1;
              bus.branch   = 1'b1;
              state_nx     = S_FETCH;
            end
            default: state_nx = S_WB;
          endcase
        end
      end
      S_MEM: begin
        bus.alu_op       = ALU_OP_W'(dec.alu_op);
        bus.mux3         = dec.mux3;
        bus.mem_read_dm  = (dec.cls == CLS_LOAD);
        bus.mem_write_dm = (dec.cls == CLS_STORE);
        if (bus.mem_ack) begin
          if (dec.cls == CLS_STORE) begin
            bus.pc_write = 1'b1;
            state_nx     = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end
      end
      S_WB: begin
        bus.alu_op       = ALU_OP_W'(dec.alu_op);
        bus.mux3         = dec.mux3;
        bus.reg_write_rf = 1'b1;
        bus.pc_write     = 1'b1;
        bus.mux2         = (dec.cls == CLS_LOAD);
        state_nx         = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb/tb_legv8_multicycle_ctrl.sv - randomized self-checking bench against a per-cycle schedule model
module tb_legv8_multicycle_ctrl;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  legv8_ctrl_if #(.OPC_W(10), .ALU_OP_W(3)) bus ();

  legv8_multicycle_ctrl #(
    .OPC_W(10), .ALU_OP_W(3), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [13:0] exp_q[$];
  logic [13:0] mask_q[$];
  logic        ack_q[$];

  localparam logic [13:0] ALL     = 14'h3fff;
  localparam logic [13:0] NO_MUX3 = 14'h3fdf;

  logic [9:0] ops [8] = '{10'b1000101000, 10'b1100101100, 10'b1111100000, 10'b0000011111,
                          10'b1111100010, 10'b1111100001, 10'b1011010000, 10'b0001010000};

  // Output word: {ready, ir_write, pc_write, rd, wr, branch, reg_write, mux2, mux3, busy, illegal, alu_op}
  function automatic logic [13:0] w(input logic rdy, irw, pcw, rd, wr, br, rw, m2, m3, bsy, ill,
                                    input logic [2:0] alu);
    return {rdy, irw, pcw, rd, wr, br, rw, m2, m3, bsy, ill, alu};
  endfunction

  function automatic logic [13:0] observed();
    return {bus.instr_ready, bus.ir_write, bus.pc_write, bus.mem_read_dm, bus.mem_write_dm,
            bus.branch, bus.reg_write_rf, bus.mux2, bus.mux3, bus.busy, bus.illegal, bus.alu_op};
  endfunction

  function automatic bit is_known(input logic [9:0] opc);
    for (int k = 0; k < 8; k++) if (opc == ops[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input int idx, input logic [13:0] e, input logic [13:0] m);
    logic [13:0] o;
    o = observed();
    checks++;
    assert ((o & m) === (e & m)) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %b required %b", tag, idx, o & m, e & m);
    end
  endtask

  task automatic push(input logic [13:0] e, input logic [13:0] m, input logic ack);
    exp_q.push_back(e);
    mask_q.push_back(m);
    ack_q.push_back(ack);
  endtask

  // Expected per-cycle schedule from the acceptance cycle through the following idle FETCH cycle.
  task automatic build(input logic [9:0] opc, input int d, input logic zf);
    logic [2:0] alu;
    logic       m3, ld, st, rtype, cbz, bra;
    int         len;
    exp_q.delete(); mask_q.delete(); ack_q.delete();
    alu = 3'b000; m3 = 1'b0; len = 1;
    ld = 1'b0; st = 1'b0; rtype = 1'b0; cbz = 1'b0; bra = 1'b0;
    case (opc)
      10'b1000101000: begin alu = 3'b010; m3 = 1'b1; rtype = 1'b1; end
      10'b1100101100: begin alu = 3'b001; m3 = 1'b1; rtype = 1'b1; end
      10'b1111100000: begin alu = 3'b100; m3 = 1'b1; rtype = 1'b1; len = MUL_LAT; end
      10'b0000011111: begin alu = 3'b011; m3 = 1'b1; rtype = 1'b1; len = DIV_LAT; end
      10'b1111100010: begin alu = 3'b010; ld = 1'b1; end
      10'b1111100001: begin alu = 3'b010; st = 1'b1; end
      10'b1011010000: begin alu = 3'b111; m3 = 1'b1; cbz = 1'b1; end
      10'b0001010000: begin bra = 1'b1; end
      default: ;
    endcase
    push(w(1,1,0,0,0,0,0,0,0,0,0,3'b000), ALL, 1'($urandom_range(0, 1)));
    if (!(rtype || ld || st || cbz || bra)) begin
      push(w(0,0,1,0,0,0,0,0,0,1,1,3'b000), ALL, 1'($urandom_range(0, 1)));
    end else begin
      push(w(0,0,0,0,0,0,0,0,0,1,0,3'b000), ALL, 1'($urandom_range(0, 1)));
      for (int i = 0; i < len; i++) begin
        push(w(0,0,cbz|bra,0,0,(cbz & zf)|bra,0,0,m3,1,0,alu), ALL, 1'($urandom_range(0, 1)));
      end
      if (ld || st) begin
        for (int i = 0; i <= d; i++) begin
          push(w(0,0,st && i == d,ld,st,0,0,0,1'b0,1,0,3'b010), ALL, i == d);
        end
      end
      if (rtype || ld) push(w(0,0,1,0,0,0,1,ld,m3,1,0,alu), NO_MUX3, 1'($urandom_range(0, 1)));
    end
    push(w(1,0,0,0,0,0,0,0,0,0,0,3'b000), ALL, 1'($urandom_range(0, 1)));
  endtask

  task automatic run(input string tag, input logic [9:0] opc, input int d, input logic zf,
                     input int abort_at);
    int n;
    build(opc, d, zf);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.instr_valid = (i == 0) ? 1'b1 : (i == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.opcode      = (i == 0) ? opc : 10'($urandom);
      bus.mem_ack     = ack_q[i];
      bus.zero_flag   = zf;
      rst             = (i == abort_at);
      #1 check(tag, i, exp_q[i], mask_q[i]);
      if (i == abort_at) begin
        @(negedge clk);
        rst = 1'b0;
        bus.instr_valid = 1'b0;
        #1 check({tag, "_after_rst"}, i + 1, w(1,0,0,0,0,0,0,0,0,0,0,3'b000), ALL);
        break;
      end
    end
  endtask

  initial begin
    logic [9:0] opc;
    bus.opcode = '0;
    bus.instr_valid = 1'b0;
    bus.zero_flag = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1 check("reset", 0, w(1,0,0,0,0,0,0,0,0,0,0,3'b000), ALL);
    end

    run("sub",     10'b1100101100, 0, 1'b0, -1);
    run("mul",     10'b1111100000, 0, 1'b0, -1);
    run("div",     10'b0000011111, 0, 1'b0, -1);
    run("ldur",    10'b1111100010, 3, 1'b0, -1);
    run("stur",    10'b1111100001, 2, 1'b0, -1);
    run("cbz_nz",  10'b1011010000, 0, 1'b0, -1);
    run("cbz_z",   10'b1011010000, 0, 1'b1, -1);
    run("b",       10'b0001010000, 0, 1'b0, -1);
    run("add",     10'b1000101000, 0, 1'b0, -1);
    run("illegal", 10'b0000000001, 0, 1'b0, -1);
    run("mul_abort", 10'b1111100000, 0, 1'b0, 3);
    run("mul_again", 10'b1111100000, 0, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      int k;
      k = $urandom_range(0, 8);
      if (k == 8) begin
        do opc = 10'($urandom); while (is_known(opc));
      end else begin
        opc = ops[k];
      end
      run("rand", opc, $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
